// File: rtl/fm_key_input.sv
// fm_key_input: front-panel key debouncer with a small event FIFO and a bus register window.
//
// Each raw key passes through a two-flop synchroniser and then a per-key debounce counter.
// A debounced press (0->1) queues that key's code into a 4-entry FIFO, which software drains
// through the EVENT register. Releases create no event. If a press finds the FIFO full and
// nothing is popped in that cycle, the press is dropped and a sticky overflow bit is set.
//
// Build option:
//   FM_KEY_IRQ_EN - when defined, irq is a registered "FIFO not empty" level.
//                   When undefined, irq is tied to 0.
//
// Parameters:
//   FM_ADDR_WIDTH   - width of the bus address ports
//   DEBOUNCE_CYCLES - stable cycles required before a key change is accepted
//
// Ports:
//   clk     - single clock
//   RST     - asynchronous active-high reset
//   key_in  - raw keys, [0]=CH_UP [1]=CH_DOWN [2]=SEEK [3]=MUTE, active-high, asynchronous
//   wraddr  - bus write address
//   wdata   - bus write data
//   wea     - bus byte write enables
//   rdaddr  - bus read address
//   rd_en   - one-cycle read strobe
//   rdata   - registered read data, held between reads
//   irq     - key event pending (level)
//
// Register map (byte addresses):
//   0x00C STATUS  read : [3:0] debounced keys, [4] empty, [5] full, [6] overflow, [9:7] count
//                 write: wea==4'hf and wdata[0]==1 clears overflow
//   0x010 EVENT   read : [1:0] head key code, [8] valid; a read of a non-empty FIFO pops it
module fm_key_input #(
  parameter int unsigned FM_ADDR_WIDTH   = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [3:0]               key_in,
  input  logic [FM_ADDR_WIDTH-1:0] wraddr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wea,
  input  logic [FM_ADDR_WIDTH-1:0] rdaddr,
  input  logic                     rd_en,
  output logic [31:0]              rdata,
  output logic                     irq
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [FM_ADDR_WIDTH-1:0] AddrStatus = FM_ADDR_WIDTH'(12);
  localparam logic [FM_ADDR_WIDTH-1:0] AddrEvent  = FM_ADDR_WIDTH'(16);

  // Synchronisers
  logic [3:0] sync1_q, sync2_q;

  // Debounce state
  logic [3:0]           deb_q, deb_d;
  logic [3:0][CntW-1:0] cnt_q, cnt_d;
  logic [3:0]           rise;

  // Pending flags and arbitration
  logic [3:0] pend_q, pend_d;
  logic [3:0] cand;
  logic       have_cand;
  logic [1:0] grant_idx;

  // Event FIFO
  logic [3:0][1:0] mem_q, mem_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop, drop;

  // Overflow and bus
  logic        ovf_q, ovf_d;
  logic        ovf_clr;
  logic [31:0] rdata_q, rdata_d;

  // Only wdata[0] carries meaning; the rest is deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:1];

  //--------------------------------------------------------------------------
  // Debounce: count while the synchronised input disagrees with the accepted
  // state; accept the new level on the cycle the count hits its maximum.
  //--------------------------------------------------------------------------
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          deb_d[k] = ~deb_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  assign rise = deb_d & ~deb_q;

  //--------------------------------------------------------------------------
  // Arbitration: a press that completes this cycle competes alongside older
  // pending presses, so a completing press can be pushed in the same cycle.
  // The lowest key index wins.
  //--------------------------------------------------------------------------
  assign cand = pend_q | rise;

  always_comb begin
    have_cand = 1'b0;
    grant_idx = 2'd0;
    // Descending scan leaves the lowest set index in grant_idx.
    for (int k = 3; k >= 0; k--) begin
      if (cand[k]) begin
        have_cand = 1'b1;
        grant_idx = 2'(k);
      end
    end
  end

  always_comb begin
    pend_d = cand;
    if (have_cand) begin
      pend_d[grant_idx] = 1'b0;
    end
  end

  //--------------------------------------------------------------------------
  // FIFO control
  //--------------------------------------------------------------------------
  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);

  assign pop  = rd_en && (rdaddr == AddrEvent) && !fifo_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
  assign push = have_cand && (!fifo_full || pop);
  assign drop = have_cand && fifo_full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  //--------------------------------------------------------------------------
  // Overflow: a drop in the same cycle as a clear wins.
  //--------------------------------------------------------------------------
  assign ovf_clr = (wraddr == AddrStatus) && (wea == 4'hf) && wdata[0];

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Read path: sampled from current state, held until the next strobe.
  //--------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      if (rdaddr == AddrStatus) begin
        rdata_d = {22'd0, count_q, ovf_q, fifo_full, fifo_empty, deb_q};
      end else if (rdaddr == AddrEvent) begin
        rdata_d = fifo_empty ? 32'd0 : {23'd0, 1'b1, 6'd0, mem_q[rd_ptr_q]};
      end else begin
        rdata_d = 32'd0;
      end
    end
  end

  assign rdata = rdata_q;

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= key_in;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef FM_KEY_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= !fifo_empty;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fm_key_input.sv
module tb_fm_key_input;

  localparam int unsigned AW = 6;
  localparam int unsigned DB = 8;
  localparam logic [5:0] A_STATUS = 6'h0C;
  localparam logic [5:0] A_EVENT  = 6'h10;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic [3:0]    key_in = '0;
  logic [AW-1:0] wraddr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wea = '0;
  logic [AW-1:0] rdaddr = '0;
  logic          rd_en = 1'b0;
  logic [31:0]   rdata;
  logic          irq;

  always #5 clk = ~clk;

  fm_key_input #(
    .FM_ADDR_WIDTH  (AW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .RST   (RST),
    .key_in(key_in),
    .wraddr(wraddr),
    .wdata (wdata),
    .wea   (wea),
    .rdaddr(rdaddr),
    .rd_en (rd_en),
    .rdata (rdata),
    .irq   (irq)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard of expected read responses
  logic [31:0] expq[$];
  logic        rd_seen = 1'b0;

  // Reference model: key levels, debounce timers, event queue, overflow, held read value.
  logic [3:0]  m_s1 = '0, m_s2 = '0, m_deb = '0, m_pend = '0;
  int          m_cnt[4] = '{0, 0, 0, 0};
  int          m_fifo[$];
  bit          m_ovf = 1'b0;
  bit          m_irq = 1'b0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) begin : model
    int          n;
    int          low;
    bit          do_pop;
    logic [3:0]  cand;
    logic [31:0] e;
    if (RST) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      m_fifo.delete();
      m_ovf = 1'b0; m_irq = 1'b0; m_rdata = '0;
      expq.delete();
      rd_seen <= 1'b0;
    end else begin
      n = m_fifo.size();
      if (rd_en) begin
        if (rdaddr == A_STATUS)
          e = 32'(m_deb) | ((n == 0) ? 32'h10 : 32'h0) | ((n == 4) ? 32'h20 : 32'h0)
              | (m_ovf ? 32'h40 : 32'h0) | (32'(n) << 7);
        else if (rdaddr == A_EVENT)
          e = (n > 0) ? (32'h100 | 32'(m_fifo[0])) : 32'h0;
        else
          e = 32'h0;
        expq.push_back(e);
        m_rdata = e;
      end
      rd_seen <= rd_en;
      do_pop = rd_en && (rdaddr == A_EVENT) && (n > 0);

      cand = m_pend;
      for (int k = 0; k < 4; k++) begin
        if (m_s2[k] == m_deb[k]) m_cnt[k] = 0;
        else if (m_cnt[k] == DB - 1) begin
          m_deb[k] = ~m_deb[k];
          m_cnt[k] = 0;
          if (m_deb[k]) cand[k] = 1'b1;
        end else m_cnt[k] = m_cnt[k] + 1;
      end

      if (wraddr == A_STATUS && wea == 4'hf && wdata[0]) m_ovf = 1'b0;
      if (do_pop) void'(m_fifo.pop_front());
      low = -1;
      for (int k = 0; k < 4; k++) if (cand[k] && low < 0) low = k;
      if (low >= 0) begin
        if (n < 4 || do_pop) m_fifo.push_back(low);
        else m_ovf = 1'b1;
        cand[low] = 1'b0;
      end
      m_pend = cand;
      m_irq  = (n != 0);
      m_s2   = m_s1;
      m_s1   = key_in;
    end
  end

  // Monitor: pops the scoreboard on each registered read, otherwise checks the hold.
  always @(negedge clk) begin
    if (!RST) begin
      if (rd_seen) begin
        if (expq.size() == 0) chk("read_without_expectation", rdata, 32'hxxxx_xxxx);
        else chk("read_data", rdata, expq.pop_front());
      end else begin
        chk("rdata_hold", rdata, m_rdata);
      end
`ifdef FM_KEY_IRQ_EN
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
`else
      chk("irq_tied_low", {31'd0, irq}, 32'd0);
`endif
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [5:0] a);
    rd_en  = 1'b1;
    rdaddr = a;
    tick(1);
    rd_en  = 1'b0;
  endtask

  // Read, then compare against a value stated directly by the register map.
  task automatic rd_chk(string name, logic [5:0] a, logic [31:0] exp);
    rd(a);
    chk(name, rdata, exp);
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d, logic [3:0] we);
    wraddr = a;
    wdata  = d;
    wea    = we;
    tick(1);
    wea    = 4'h0;
  endtask

  task automatic press(int k);
    key_in[k] = 1'b1;
    tick(14);
    key_in[k] = 1'b0;
    tick(14);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    RST = 1'b0;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    tick(2);
    rd_chk("reset_status", A_STATUS, 32'h10);

    // Single long press on CH_UP
    key_in[0] = 1'b1; tick(20); key_in[0] = 1'b0; tick(12);
    rd_chk("ch_up_event", A_EVENT, 32'h100);
    rd_chk("ch_up_status", A_STATUS, 32'h10);

    // Short glitch on SEEK is filtered
    key_in[2] = 1'b1; tick(5); key_in[2] = 1'b0; tick(20);
    rd_chk("glitch_status", A_STATUS, 32'h10);
    rd_chk("glitch_event", A_EVENT, 32'h0);

    // Five presses overflow the FIFO
    press(0); press(1); press(2); press(3); press(0);
    rd_chk("overflow_status", A_STATUS, 32'h260);
    wr(A_STATUS, 32'h1, 4'h3);
    rd_chk("partial_wea_ignored", A_STATUS, 32'h260);
    wr(A_STATUS, 32'h1, 4'hf);
    rd_chk("overflow_cleared", A_STATUS, 32'h220);
    for (int i = 0; i < 4; i++) rd_chk("drain_order", A_EVENT, 32'h100 | 32'(i));
    rd_chk("empty_event", A_EVENT, 32'h0);
    rd_chk("empty_status", A_STATUS, 32'h10);

    // Simultaneous CH_DOWN and MUTE: lower index first
    key_in = 4'b1010; tick(14); key_in = 4'b0000; tick(14);
    rd_chk("simul_first", A_EVENT, 32'h101);
    rd_chk("simul_second", A_EVENT, 32'h103);

    // Full FIFO, debounce completing on the same edge as a pop
    press(0); press(1); press(2); press(3);
    key_in[0] = 1'b1;
    tick(9);
    rd_chk("pop_with_push", A_EVENT, 32'h100);
    tick(14); key_in[0] = 1'b0; tick(14);
    rd_chk("pop_push_status", A_STATUS, 32'h220);
    rd_chk("pp_drain1", A_EVENT, 32'h101);
    rd_chk("pp_drain2", A_EVENT, 32'h102);
    rd_chk("pp_drain3", A_EVENT, 32'h103);
    rd_chk("pp_drain4", A_EVENT, 32'h100);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) key_in[$urandom_range(3)] ^= 1'b1;
      rd_en = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0, 1:    rdaddr = A_EVENT;
        2:       rdaddr = A_STATUS;
        default: rdaddr = 6'($urandom);
      endcase
      if ($urandom_range(31) == 0) begin
        wraddr = ($urandom_range(1) == 0) ? A_STATUS : 6'($urandom);
        wdata  = $urandom;
        wea    = ($urandom_range(1) == 0) ? 4'hf : 4'($urandom);
      end else begin
        wea = 4'h0;
      end
      tick(1);
    end
    rd_en = 1'b0; wea = 4'h0; key_in = 4'h0;
    tick(20);
    for (int i = 0; i < 5; i++) rd(A_EVENT);
    rd(A_STATUS);

    // Reset in the middle of a MUTE debounce
    key_in[3] = 1'b1;
    tick(6);
    RST = 1'b1; key_in[3] = 1'b0;
    tick(2);
    RST = 1'b0;
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    tick(20);
    chk("midreset_irq_later", {31'd0, irq}, 32'd0);
    rd_chk("midreset_status", A_STATUS, 32'h10);
    rd_chk("midreset_event", A_EVENT, 32'h0);

    tick(3);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
